// File: rtl/frame_cfg_pkg.sv
// frame_cfg_pkg: shared constants and FSM state encoding for the frame strobe controller.
package frame_cfg_pkg;

    // Width of the frame index carried on cmd_frame.
    localparam int unsigned FrameIdxW      = 5;
    // Width of the saturating strobe counter.
    localparam int unsigned FramesWrittenW = 16;
    // Strobe-length counter width, enough for 1..15 cycles.
    localparam int unsigned StrobeCntW     = 4;

    // Plain logic encoding keeps the states usable by older tools.
    typedef logic [1:0] fsm_state_t;

    localparam fsm_state_t StIdle   = 2'd0;
    localparam fsm_state_t StSetup  = 2'd1;
    localparam fsm_state_t StStrobe = 2'd2;
    localparam fsm_state_t StHold   = 2'd3;

endpackage

// File: rtl/frame_strobe_decode.sv
// frame_strobe_decode: combinational frame index to one-hot strobe decode, gated by enable.
module frame_strobe_decode
    import frame_cfg_pkg::*;
#(
    parameter int unsigned NumStrobes = 20
) (
    input  logic                  i_en,
    input  logic [FrameIdxW-1:0]  i_idx,
    output logic [NumStrobes-1:0] o_strobe
);

    // One strobe line per frame; indices beyond the column decode to all-zero.
    always_comb begin
        o_strobe = '0;
        for (int unsigned k = 0; k < NumStrobes; k++) begin
            o_strobe[k] = i_en && (i_idx == FrameIdxW'(k));
        end
    end

endmodule

// File: rtl/frame_strobe_ctrl.sv
// frame_strobe_ctrl: accepts frame write commands, presents the payload on FrameData,
// then pulses a one-hot FrameStrobe after a one-cycle setup and before a one-cycle hold.
// Optional feature: define FRAME_PARITY_EN to add cmd_parity (even parity over
// {cmd_frame, cmd_data}); a mismatch is rejected exactly like an out-of-range frame.
module frame_strobe_ctrl
    import frame_cfg_pkg::*;
#(
    parameter int unsigned MaxFramesPerCol     = 20,
    parameter int unsigned FrameBitsPerRow     = 32,
    parameter int unsigned STROBE_CYCLES       = 1,
    // Reset value of frames_written; 0 in normal use.
    parameter int unsigned FramesWrittenRstVal = 0
) (
    input  logic                       CLK,
    input  logic                       RST,
    input  logic                       cmd_valid,
    output logic                       cmd_ready,
    input  logic [FrameIdxW-1:0]       cmd_frame,
    input  logic [FrameBitsPerRow-1:0] cmd_data,
`ifdef FRAME_PARITY_EN
    input  logic                       cmd_parity,
`endif
    output logic [FrameBitsPerRow-1:0] FrameData,
    output logic [MaxFramesPerCol-1:0] FrameStrobe,
    output logic                       busy,
    output logic                       err,
    input  logic                       err_clr,
    output logic [FramesWrittenW-1:0]  frames_written
);

    fsm_state_t                 r_state;
    fsm_state_t                 w_state_next;
    logic [FrameIdxW-1:0]       r_frame;
    logic [FrameBitsPerRow-1:0] r_data;
    logic [StrobeCntW-1:0]      r_strobe_cnt;
    logic                       r_err;
    logic [FramesWrittenW-1:0]  r_frames_written;

    logic w_handshake;
    logic w_frame_ok;
    logic w_parity_ok;
    logic w_accept;
    logic w_reject;
    logic w_strobe_en;

    assign cmd_ready   = (r_state == StIdle);
    assign w_handshake = cmd_valid && cmd_ready;
    assign w_frame_ok  = (32'(cmd_frame) < MaxFramesPerCol);

`ifdef FRAME_PARITY_EN
    // Even parity: XOR over payload, index and parity bit must be zero.
    assign w_parity_ok = ~(^{cmd_parity, cmd_frame, cmd_data});
`else
    assign w_parity_ok = 1'b1;
`endif

    assign w_accept    = w_handshake && w_frame_ok && w_parity_ok;
    assign w_reject    = w_handshake && !(w_frame_ok && w_parity_ok);
    assign w_strobe_en = (r_state == StStrobe);

    // Next-state logic: IDLE -> SETUP -> STROBE (STROBE_CYCLES) -> HOLD -> IDLE.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            StIdle:   if (w_accept) w_state_next = StSetup;
            StSetup:  w_state_next = StStrobe;
            StStrobe: if (r_strobe_cnt == '0) w_state_next = StHold;
            StHold:   w_state_next = StIdle;
            default:  w_state_next = StIdle;
        endcase
    end

    // State register.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_state <= StIdle;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Capture payload and target index on an accepted command; held between commands.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_frame <= '0;
            r_data  <= '0;
        end else if (w_accept) begin
            r_frame <= cmd_frame;
            r_data  <= cmd_data;
        end
    end

    // Remaining strobe cycles; loaded in SETUP so STROBE exits when it reaches zero.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_strobe_cnt <= '0;
        end else if (r_state == StSetup) begin
            r_strobe_cnt <= StrobeCntW'(STROBE_CYCLES - 1);
        end else if (w_strobe_en && (r_strobe_cnt != '0)) begin
            r_strobe_cnt <= r_strobe_cnt - 1'b1;
        end
    end

    // Sticky error; a new rejection wins over a simultaneous clear.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_err <= 1'b0;
        end else if (w_reject) begin
            r_err <= 1'b1;
        end else if (err_clr) begin
            r_err <= 1'b0;
        end
    end

    // Saturating strobe count, bumped on entry into the first STROBE cycle.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_frames_written <= FramesWrittenW'(FramesWrittenRstVal);
        end else if ((r_state == StSetup) && (r_frames_written != '1)) begin
            r_frames_written <= r_frames_written + 1'b1;
        end
    end

    // Strobe is decoded from registered state, so reset drops it without a clock edge.
    frame_strobe_decode #(
        .NumStrobes (MaxFramesPerCol)
    ) u_decode (
        .i_en     (w_strobe_en),
        .i_idx    (r_frame),
        .o_strobe (FrameStrobe)
    );

    assign FrameData      = r_data;
    assign busy           = (r_state != StIdle);
    assign err            = r_err;
    assign frames_written = r_frames_written;

endmodule

// File: doc/frame_strobe_ctrl.md
FRAME_STROBE_CTRL -- requirements
Module: frame_strobe_ctrl

Interface
REQ-001 SHALL have parameter MaxFramesPerCol, default 20: number of frame strobes driven into the tile column.
REQ-002 SHALL have parameter FrameBitsPerRow, default 32: FrameData width.
REQ-003 SHALL have parameter STROBE_CYCLES, default 1, legal range 1..15: number of cycles the strobe is held high.
REQ-004 SHALL have port CLK, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-005 SHALL have port RST, input, 1 bit: reset, asynchronous and active-high.
REQ-006 SHALL have port cmd_valid, input, 1 bit: a write command is present.
REQ-007 SHALL have port cmd_ready, output, 1 bit: the block accepts a command this cycle.
REQ-008 SHALL have port cmd_frame, input, 5 bits: target frame index.
REQ-009 SHALL have port cmd_data, input, FrameBitsPerRow bits: frame payload.
REQ-010 SHALL have port FrameData, output, FrameBitsPerRow bits: registered payload to the column.
REQ-011 SHALL have port FrameStrobe, output, MaxFramesPerCol bits: one-hot write strobe.
REQ-012 SHALL have port busy, output, 1 bit: high whenever the FSM is not in IDLE.
REQ-013 SHALL have port err, output, 1 bit: sticky error flag.
REQ-014 SHALL have port err_clr, input, 1 bit: clears err.
REQ-015 SHALL have port frames_written, output, 16 bits: saturating count of strobes issued.

Function
REQ-016 SHALL implement FSM states IDLE, SETUP, STROBE, HOLD.
REQ-017 SHALL drive cmd_ready=1 only in IDLE; a handshake occurs on cmd_valid&&cmd_ready.
REQ-018 On a handshake with a legal frame (cmd_frame<MaxFramesPerCol), SHALL register cmd_data into FrameData and cmd_frame internally, then go to SETUP.
REQ-019 SETUP SHALL last 1 cycle with FrameStrobe all-zero, so the data is stable before the strobe.
REQ-020 STROBE SHALL assert FrameStrobe[frame] alone for exactly STROBE_CYCLES cycles.
REQ-021 HOLD SHALL last 1 cycle with FrameStrobe=0 and FrameData unchanged, then return to IDLE.
REQ-022 Accept-to-next-ready latency SHALL be 3+STROBE_CYCLES cycles.
REQ-023 On a handshake with an illegal frame (cmd_frame>=MaxFramesPerCol): no FrameData update, no strobe, err set, FSM stays in IDLE.
REQ-024 frames_written SHALL increment on the first STROBE cycle of each command and saturate at 0xFFFF.
REQ-025 err_clr SHALL clear err; if err_clr and a new error occur in the same cycle, err SHALL end up set.
REQ-026 FrameData SHALL hold its last value between commands.
REQ-027 cmd_valid outside IDLE SHALL be ignored with no side effects.

Reset
REQ-028 RST high SHALL immediately (asynchronously) force IDLE, FrameData=0, FrameStrobe=0, err=0, frames_written=0, busy=0; this includes reset asserted mid-STROBE, which SHALL drop the strobe without waiting for a clock.
REQ-029 After RST deasserts, cmd_ready SHALL be 1 on the first clock edge.

Configuration
REQ-030 With macro FRAME_PARITY_EN defined, the block SHALL add input cmd_parity (1 bit) carrying even parity over {cmd_frame,cmd_data}.
REQ-031 With FRAME_PARITY_EN defined, a parity mismatch SHALL be handled like an illegal frame (REQ-023).
REQ-032 Without FRAME_PARITY_EN, the port and the check SHALL be absent.

Structure
REQ-033 Package frame_cfg_pkg SHALL hold the FSM state typedef, the frame-index width constant, and the frames_written width constant.
REQ-034 Sub-module frame_strobe_decode SHALL provide combinational index-to-one-hot decode gated by an enable.
REQ-035 FSM, counters and error logic SHALL reside in frame_strobe_ctrl.

Verification
REQ-036 Reset; cmd frame=5, data=0xDEADBEEF -> FrameData=0xDEADBEEF after 1 cycle; FrameStrobe=0x00020 for 1 cycle after SETUP; cmd_ready returns after 4 cycles; frames_written=1.
REQ-037 With STROBE_CYCLES=3, cmd frame=19 -> FrameStrobe[19] high for exactly 3 cycles; ready after 6 cycles.
REQ-038 cmd frame=20 -> no strobe, FrameData unchanged, err=1; err_clr pulse -> err=0; err_clr coinciding with a frame=25 command -> err=1.
REQ-039 RST asserted during STROBE -> FrameStrobe=0 before the next edge, all outputs at reset values.
REQ-040 Preload frames_written to 0xFFFE, issue 3 commands -> count stops at 0xFFFF.
REQ-041 With FRAME_PARITY_EN, a wrong-parity command -> no strobe, err=1; a correct-parity command -> normal strobe.
